// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-master Avalon-MM arbiter in front of one SDRAM controller.
// Commands pass through combinationally under round-robin arbitration. A tag
// FIFO records which master issued each outstanding read so returning
// readdatavalid pulses are routed back to their owners.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   m0_* / m1_*                        Avalon-MM master-side command/response
//   s_*                                Avalon-MM command to / response from SDRAM ctrl
//   pending_count                      reads currently outstanding
//   rdv_err                            sticky: readdatavalid with nothing outstanding
module sdram_arbiter #(
  parameter int unsigned ADDR_W   = 26,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_PEND = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         m0_address,
  input  logic                      m0_read,
  input  logic                      m0_write,
  input  logic [DATA_W-1:0]         m0_writedata,
  input  logic [DATA_W/8-1:0]       m0_byteenable,
  output logic                      m0_waitrequest,
  output logic [DATA_W-1:0]         m0_readdata,
  output logic                      m0_readdatavalid,
  input  logic [ADDR_W-1:0]         m1_address,
  input  logic                      m1_read,
  input  logic                      m1_write,
  input  logic [DATA_W-1:0]         m1_writedata,
  input  logic [DATA_W/8-1:0]       m1_byteenable,
  output logic                      m1_waitrequest,
  output logic [DATA_W-1:0]         m1_readdata,
  output logic                      m1_readdatavalid,
  output logic [ADDR_W-1:0]         s_address,
  output logic                      s_read,
  output logic                      s_write,
  output logic [DATA_W-1:0]         s_writedata,
  output logic [DATA_W/8-1:0]       s_byteenable,
  input  logic                      s_waitrequest,
  input  logic [DATA_W-1:0]         s_readdata,
  input  logic                      s_readdatavalid,
  output logic [$clog2(MAX_PEND):0] pending_count,
  output logic                      rdv_err
);

  localparam int unsigned PTR_W = $clog2(MAX_PEND);
  localparam int unsigned CNT_W = PTR_W + 1;

  // State registers
  logic                r_last;
  logic                r_hold;
  logic                r_hold_id;
  logic                r_err;
  logic [MAX_PEND-1:0] r_tag;
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;

  // Next-state values
  logic                w_last_nxt;
  logic                w_hold_nxt;
  logic                w_hold_id_nxt;
  logic                w_err_nxt;
  logic [MAX_PEND-1:0] w_tag_nxt;
  logic [PTR_W-1:0]    w_wptr_nxt;
  logic [PTR_W-1:0]    w_rptr_nxt;
  logic [CNT_W-1:0]    w_count_nxt;

  // Combinational datapath
  logic w_req0;
  logic w_req1;
  logic w_sel;
  logic w_sel_vld;
  logic w_rd;
  logic w_wr;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_blocked;
  logic w_accept;
  logic w_head;

  // Grant selection, command mux and response routing
  always_comb begin
    w_req0    = m0_read | m0_write;
    w_req1    = m1_read | m1_write;
    w_sel     = 1'b0;
    w_sel_vld = 1'b0;
    if (r_hold) begin
      // A stalled command keeps its grant until accepted
      w_sel     = r_hold_id;
      w_sel_vld = r_hold_id ? w_req1 : w_req0;
    end else if (w_req0 & w_req1) begin
      w_sel     = ~r_last;
      w_sel_vld = 1'b1;
    end else if (w_req0) begin
      w_sel     = 1'b0;
      w_sel_vld = 1'b1;
    end else if (w_req1) begin
      w_sel     = 1'b1;
      w_sel_vld = 1'b1;
    end
    // Nothing is forwarded while reset is held
    w_sel_vld = w_sel_vld & reset_n;

    // Read wins if a master asserts both
    w_rd = w_sel_vld & (w_sel ? m1_read : m0_read);
    w_wr = w_sel_vld & ~(w_sel ? m1_read : m0_read) & (w_sel ? m1_write : m0_write);

    w_empty = (r_count == '0);
    w_full  = (r_count == CNT_W'(MAX_PEND));
    w_pop   = s_readdatavalid & ~w_empty;
    // A pop in the same cycle frees a slot for the stalled read
    w_blocked = w_rd & w_full & ~w_pop;

    s_read       = w_rd & ~w_blocked;
    s_write      = w_wr;
    s_address    = w_sel ? m1_address    : m0_address;
    s_writedata  = w_sel ? m1_writedata  : m0_writedata;
    s_byteenable = w_sel ? m1_byteenable : m0_byteenable;

    w_accept = (s_read | s_write) & ~s_waitrequest;
    w_push   = w_accept & s_read;

    m0_waitrequest = ~(w_sel_vld & ~w_sel & ~w_blocked & ~s_waitrequest);
    m1_waitrequest = ~(w_sel_vld &  w_sel & ~w_blocked & ~s_waitrequest);

    w_head           = r_tag[r_rptr];
    m0_readdatavalid = w_pop & ~w_head;
    m1_readdatavalid = w_pop &  w_head;
    m0_readdata      = s_readdata;
    m1_readdata      = s_readdata;

    pending_count = r_count;
    rdv_err       = r_err;
  end

  // Next-state: round-robin pointer, grant hold, tag FIFO, error flag
  always_comb begin
    w_last_nxt    = r_last;
    w_hold_nxt    = r_hold;
    w_hold_id_nxt = r_hold_id;
    w_err_nxt     = r_err;
    w_tag_nxt     = r_tag;
    w_wptr_nxt    = r_wptr;
    w_rptr_nxt    = r_rptr;
    w_count_nxt   = r_count;

    if (w_accept) begin
      w_last_nxt = w_sel;
      w_hold_nxt = 1'b0;
    end else if (w_sel_vld) begin
      w_hold_nxt    = 1'b1;
      w_hold_id_nxt = w_sel;
    end else begin
      w_hold_nxt = 1'b0;
    end

    if (w_push) begin
      w_tag_nxt[r_wptr] = w_sel;
      w_wptr_nxt        = r_wptr + PTR_W'(1);
    end
    if (w_pop) begin
      w_rptr_nxt = r_rptr + PTR_W'(1);
    end

    if (w_push & ~w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (~w_push & w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end

    if (s_readdatavalid & w_empty) begin
      w_err_nxt = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last    <= 1'b1;
      r_hold    <= 1'b0;
      r_hold_id <= 1'b0;
      r_err     <= 1'b0;
      r_tag     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      r_last    <= w_last_nxt;
      r_hold    <= w_hold_nxt;
      r_hold_id <= w_hold_id_nxt;
      r_err     <= w_err_nxt;
      r_tag     <= w_tag_nxt;
      r_wptr    <= w_wptr_nxt;
      r_rptr    <= w_rptr_nxt;
      r_count   <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_arbiter;

  localparam int unsigned ADDR_W   = 26;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_PEND = 8;
  localparam int          LAT      = 3;

  logic                clk;
  logic                reset_n;
  logic [ADDR_W-1:0]   m0_address, m1_address, s_address;
  logic                m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0]   m0_writedata, m1_writedata, s_writedata;
  logic [3:0]          m0_byteenable, m1_byteenable, s_byteenable;
  logic                m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0]   m0_readdata, m1_readdata, s_readdata;
  logic                m0_readdatavalid, m1_readdatavalid;
  logic                s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [3:0]          pending_count;
  logic                rdv_err;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .pending_count(pending_count), .rdv_err(rdv_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: queue of outstanding reads (owner + expected data)
  typedef struct { int owner; logic [DATA_W-1:0] data; } tag_t;
  typedef struct { int due;   logic [DATA_W-1:0] data; } rsp_t;
  tag_t tagq[$];
  rsp_t sq[$];
  int   md_last, md_lock, md_lock_id;
  bit   md_err;

  int   errors = 0;
  int   checks = 0;
  int   cnum   = 0;
  bit   auto_slv, fixed_lat, rnd_mode;

  int                e_g;
  bit                e_v, e_sread, e_swrite, e_acc, e_pop, e_w0, e_w1;
  logic [DATA_W-1:0] e_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [3:0] be);
    if (i == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic new_req(input int i);
    int r;
    logic rd, wr;
    r  = int'($urandom_range(0, 99));
    rd = 1'b0;
    wr = 1'b0;
    if (r < 35) rd = 1'b1;
    else if (r < 65) wr = 1'b1;
    else if (r < 70) begin rd = 1'b1; wr = 1'b1; end
    set_m(i, rd, wr, ADDR_W'($urandom), $urandom, 4'($urandom));
  endtask

  // Expected outputs for the current cycle from the arbitration rules
  task automatic check_cycle();
    logic rq[2], rd_a[2], wr_a[2];
    logic [ADDR_W-1:0] ad_a[2];
    logic [DATA_W-1:0] wd_a[2];
    logic [3:0]        be_a[2];
    bit e_rd, e_wr, e_blk, e_rdv0, e_rdv1;
    int nq;
    rd_a[0] = m0_read;  wr_a[0] = m0_write;  ad_a[0] = m0_address;
    wd_a[0] = m0_writedata; be_a[0] = m0_byteenable;
    rd_a[1] = m1_read;  wr_a[1] = m1_write;  ad_a[1] = m1_address;
    wd_a[1] = m1_writedata; be_a[1] = m1_byteenable;
    rq[0] = rd_a[0] | wr_a[0];
    rq[1] = rd_a[1] | wr_a[1];
    nq  = tagq.size();
    e_v = 1'b0;
    e_g = 0;
    if (reset_n) begin
      if (md_lock != 0) begin e_g = md_lock_id; e_v = rq[e_g]; end
      else if (rq[0] && rq[1]) begin e_g = 1 - md_last; e_v = 1'b1; end
      else if (rq[0]) begin e_g = 0; e_v = 1'b1; end
      else if (rq[1]) begin e_g = 1; e_v = 1'b1; end
    end
    e_addr   = DATA_W'(ad_a[e_g]);
    e_pop    = reset_n && s_readdatavalid && nq > 0;
    e_rd     = e_v && rd_a[e_g];
    e_wr     = e_v && !rd_a[e_g] && wr_a[e_g];
    e_blk    = e_rd && nq == MAX_PEND && !e_pop;
    e_sread  = e_rd && !e_blk;
    e_swrite = e_wr;
    e_acc    = (e_sread || e_swrite) && !s_waitrequest;
    e_w0     = !(e_v && e_g == 0 && !e_blk && !s_waitrequest);
    e_w1     = !(e_v && e_g == 1 && !e_blk && !s_waitrequest);
    e_rdv0   = e_pop && tagq[0].owner == 0;
    e_rdv1   = e_pop && tagq[0].owner == 1;

    chk("s_read", 64'(s_read), 64'(e_sread));
    chk("s_write", 64'(s_write), 64'(e_swrite));
    chk("m0_waitrequest", 64'(m0_waitrequest), 64'(e_w0));
    chk("m1_waitrequest", 64'(m1_waitrequest), 64'(e_w1));
    chk("m0_readdatavalid", 64'(m0_readdatavalid), 64'(e_rdv0));
    chk("m1_readdatavalid", 64'(m1_readdatavalid), 64'(e_rdv1));
    chk("pending_count", 64'(pending_count), 64'(nq));
    chk("rdv_err", 64'(rdv_err), 64'(md_err));
    if (e_sread || e_swrite) chk("s_address", 64'(s_address), 64'(ad_a[e_g]));
    if (e_swrite) begin
      chk("s_writedata", 64'(s_writedata), 64'(wd_a[e_g]));
      chk("s_byteenable", 64'(s_byteenable), 64'(be_a[e_g]));
    end
    if (e_rdv0) chk("m0_readdata", 64'(m0_readdata), 64'(tagq[0].data));
    if (e_rdv1) chk("m1_readdata", 64'(m1_readdata), 64'(tagq[0].data));
  endtask

  task automatic model_update();
    if (s_readdatavalid && tagq.size() == 0) md_err = 1'b1;
    if (e_pop) void'(tagq.pop_front());
    if (e_acc && e_sread) tagq.push_back('{e_g, e_addr});
    if (e_acc) begin
      md_last = e_g;
      md_lock = 0;
    end else if (e_v) begin
      md_lock    = 1;
      md_lock_id = e_g;
    end else begin
      md_lock = 0;
    end
  endtask

  // One clock: check at negedge, advance model at posedge, drive next inputs
  task automatic cyc();
    if (clk == 1'b1) @(negedge clk);
    check_cycle();
    if (reset_n && s_read && !s_waitrequest) sq.push_back('{cnum + LAT, DATA_W'(s_address)});
    @(posedge clk);
    if (reset_n) model_update();
    cnum++;
    #1;
    s_readdatavalid = 1'b0;
    if (auto_slv && sq.size() > 0 && sq[0].due <= cnum &&
        (fixed_lat || $urandom_range(0, 1) == 1)) begin
      s_readdatavalid = 1'b1;
      s_readdata      = sq[0].data;
      void'(sq.pop_front());
    end
    if (rnd_mode) begin
      if (!e_w0 || !(m0_read || m0_write)) new_req(0);
      if (!e_w1 || !(m1_read || m1_write)) new_req(1);
      s_waitrequest = ($urandom_range(0, 99) < 30);
    end
  endtask

  task automatic rdv_pulse();
    s_readdatavalid = 1'b1;
    if (sq.size() > 0) begin
      s_readdata = sq[0].data;
      void'(sq.pop_front());
    end else begin
      s_readdata = 32'h5A5A_5A5A;
    end
  endtask

  task automatic idle_masters();
    set_m(0, 1'b0, 1'b0, '0, '0, 4'h0);
    set_m(1, 1'b0, 1'b0, '0, '0, 4'h0);
  endtask

  task automatic drain();
    int n;
    idle_masters();
    rnd_mode      = 1'b0;
    auto_slv      = 1'b1;
    fixed_lat     = 1'b0;
    s_waitrequest = 1'b0;
    n = 0;
    while ((tagq.size() > 0 || sq.size() > 0) && n < 200) begin
      cyc();
      n++;
    end
    cyc();
    chk("drain_pending", 64'(pending_count), 64'(0));
    auto_slv = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rnd_mode = 1'b0;
    auto_slv = 1'b0;
    new_req(0);
    new_req(1);
    s_waitrequest   = 1'($urandom);
    s_readdatavalid = 1'($urandom);
    s_readdata      = $urandom;
    tagq.delete();
    sq.delete();
    md_last = 1; md_lock = 0; md_lock_id = 0; md_err = 1'b0;
    repeat (2) cyc();
    idle_masters();
    s_waitrequest   = 1'b0;
    s_readdatavalid = 1'b0;
    reset_n         = 1'b1;
  endtask

  int n0, n1;

  initial begin
    reset_n = 1'b0;
    idle_masters();
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
    auto_slv = 1'b0; fixed_lat = 1'b0; rnd_mode = 1'b0;
    @(posedge clk);
    #1;

    // Reset with random inputs
    do_reset();
    @(negedge clk);
    chk("rst_pending", 64'(pending_count), 64'(0));
    chk("rst_rdv_err", 64'(rdv_err), 64'(0));
    chk("rst_idle_wait0", 64'(m0_waitrequest), 64'(1));
    cyc();

    // Contention: continuous reads from both masters, 3-cycle read latency
    set_m(0, 1'b1, 1'b0, ADDR_W'('h100), '0, 4'hF);
    set_m(1, 1'b1, 1'b0, ADDR_W'('h200), '0, 4'hF);
    s_waitrequest = 1'b0;
    auto_slv  = 1'b1;
    fixed_lat = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("cont_addr", 64'(s_address), 64'((k % 2 == 0) ? 'h100 : 'h200));
      if (m0_readdatavalid) begin chk("cont_rd0", 64'(m0_readdata), 64'('h100)); n0++; end
      if (m1_readdatavalid) begin chk("cont_rd1", 64'(m1_readdata), 64'('h200)); n1++; end
      cyc();
    end
    chk("cont_n0", 64'(n0), 64'(5));
    chk("cont_n1", 64'(n1), 64'(4));
    drain();

    // Stall hold: m1 write held through 4 waitrequest cycles, m0 read waits
    set_m(1, 1'b0, 1'b1, ADDR_W'('h40), 32'hDEAD_BEEF, 4'hF);
    s_waitrequest = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k >= 1) set_m(0, 1'b1, 1'b0, ADDR_W'('h80), '0, 4'hF);
      if (k == 4) s_waitrequest = 1'b0;
      @(negedge clk);
      chk("hold_s_write", 64'(s_write), 64'(1));
      chk("hold_addr", 64'(s_address), 64'('h40));
      chk("hold_wdata", 64'(s_writedata), 64'(32'hDEAD_BEEF));
      chk("hold_m0_wait", 64'(m0_waitrequest), 64'(1));
      chk("hold_m1_wait", 64'(m1_waitrequest), 64'((k == 4) ? 0 : 1));
      cyc();
    end
    set_m(1, 1'b0, 1'b0, '0, '0, 4'h0);
    @(negedge clk);
    chk("hold_m0_grant", 64'(m0_waitrequest), 64'(0));
    chk("hold_m0_addr", 64'(s_address), 64'('h80));
    cyc();
    drain();

    // FIFO full: 8 reads outstanding, 9th stalls, a write still passes
    for (int k = 0; k < 8; k++) begin
      set_m(0, 1'b1, 1'b0, ADDR_W'('h1000 + k * 4), '0, 4'hF);
      @(negedge clk);
      chk("full_fill_acc", 64'(m0_waitrequest), 64'(0));
      cyc();
    end
    set_m(0, 1'b1, 1'b0, ADDR_W'('h2000), '0, 4'hF);
    set_m(1, 1'b0, 1'b1, ADDR_W'('h300), 32'h1234_5678, 4'h3);
    @(negedge clk);
    chk("full_pending", 64'(pending_count), 64'(8));
    chk("full_wr_pass", 64'(s_write), 64'(1));
    chk("full_wr_addr", 64'(s_address), 64'('h300));
    chk("full_m1_wait", 64'(m1_waitrequest), 64'(0));
    cyc();
    set_m(1, 1'b0, 1'b0, '0, '0, 4'h0);
    repeat (2) begin
      @(negedge clk);
      chk("full_stall_rd", 64'(s_read), 64'(0));
      chk("full_stall_wait", 64'(m0_waitrequest), 64'(1));
      chk("full_stall_cnt", 64'(pending_count), 64'(8));
      cyc();
    end
    rdv_pulse();
    @(negedge clk);
    chk("full_rel_rdv", 64'(m0_readdatavalid), 64'(1));
    chk("full_rel_rd", 64'(s_read), 64'(1));
    chk("full_rel_wait", 64'(m0_waitrequest), 64'(0));
    chk("full_rel_addr", 64'(s_address), 64'('h2000));
    cyc();
    set_m(0, 1'b0, 1'b0, '0, '0, 4'h0);
    @(negedge clk);
    chk("full_after_cnt", 64'(pending_count), 64'(8));
    cyc();
    drain();

    // Simultaneous push/pop at pending_count = 3
    for (int k = 0; k < 3; k++) begin
      set_m(0, 1'b1, 1'b0, ADDR_W'('h500 + k * 4), '0, 4'hF);
      cyc();
    end
    set_m(0, 1'b0, 1'b0, '0, '0, 4'h0);
    set_m(1, 1'b1, 1'b0, ADDR_W'('h600), '0, 4'hF);
    rdv_pulse();
    @(negedge clk);
    chk("pp_cnt_before", 64'(pending_count), 64'(3));
    chk("pp_rdv0", 64'(m0_readdatavalid), 64'(1));
    chk("pp_m1_acc", 64'(m1_waitrequest), 64'(0));
    cyc();
    set_m(1, 1'b0, 1'b0, '0, '0, 4'h0);
    @(negedge clk);
    chk("pp_cnt_after", 64'(pending_count), 64'(3));
    cyc();
    for (int j = 0; j < 3; j++) begin
      rdv_pulse();
      @(negedge clk);
      chk("pp_order_m0", 64'(m0_readdatavalid), 64'((j < 2) ? 1 : 0));
      chk("pp_order_m1", 64'(m1_readdatavalid), 64'((j == 2) ? 1 : 0));
      cyc();
    end

    // Spurious readdatavalid with nothing outstanding
    rdv_pulse();
    @(negedge clk);
    chk("spur_rdv0", 64'(m0_readdatavalid), 64'(0));
    chk("spur_rdv1", 64'(m1_readdatavalid), 64'(0));
    cyc();
    repeat (3) begin
      @(negedge clk);
      chk("spur_sticky", 64'(rdv_err), 64'(1));
      cyc();
    end
    do_reset();
    @(negedge clk);
    chk("spur_cleared", 64'(rdv_err), 64'(0));
    cyc();

    // Randomized traffic against the model, with a reset mid-stream
    for (int pass = 0; pass < 2; pass++) begin
      new_req(0);
      new_req(1);
      rnd_mode  = 1'b1;
      auto_slv  = 1'b1;
      fixed_lat = 1'b0;
      repeat (1500) cyc();
      if (pass == 0) do_reset();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-master Avalon-MM arbiter that shares the single SDRAM controller slave of the DE1-SoC system between the Tiger processor data master (m0) and an HLS accelerator master (m1). It sits between both masters and the SDRAM controller's s1 port. Commands pass through combinationally under round-robin arbitration. A tag FIFO records the owner of every outstanding pipelined read, so each `readdatavalid` is routed back to the master that issued that read.

## Interface
Parameters:
- ADDR_W, 26, byte address width (64 MB SDRAM)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- MAX_PEND, 8, maximum outstanding reads (tag FIFO depth, power of 2, ≥2)

Ports:
- clk  in  1  system clock (50 MHz PLL output)
- reset_n  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  master byte address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_waitrequest / m1_waitrequest  out  1  stall to master
- m0_readdata / m1_readdata  out  DATA_W  read data (s_readdata fanned out)
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid
- s_address  out  ADDR_W, s_read / s_write  out  1, s_writedata  out  DATA_W, s_byteenable  out  DATA_W/8  command to SDRAM controller
- s_waitrequest  in  1, s_readdata  in  DATA_W, s_readdatavalid  in  1  responses from the controller
- pending_count  out  $clog2(MAX_PEND)+1  number of reads outstanding
- rdv_err  out  1  sticky flag: readdatavalid arrived with no outstanding read

## Operation
- req[i] = mi_read | mi_write. A master never asserts read and write together; if it does, read takes precedence.
- Registers and reset values:
  - last = 1, so m0 wins first.
  - hold = 0, hold_id = 0.
  - FIFO empty, pending_count = 0.
  - rdv_err = 0.
- Select logic:
  - If hold = 1, sel = hold_id.
  - Otherwise sel is the requester after `last` in round-robin order. With a single requester, that requester is selected.
- blocked = (selected command is a read) & (pending_count == MAX_PEND).
- s_read / s_write = selected master's read / write, gated by ~blocked. When nothing is selected, both are 0.
- s_address, s_writedata and s_byteenable mux the selected master's signals. They are don't-care when idle.
- mi_waitrequest = ~(req[i] & sel==i & ~blocked & ~s_waitrequest). It is 1 when master i is idle or not selected.
- accept = (s_read | s_write) & ~s_waitrequest.
  - On accept: last <= sel, hold <= 0.
  - If the accepted command is a read, sel is pushed into the tag FIFO.
- Command presented but not accepted (s_waitrequest = 1 or blocked): hold <= 1, hold_id <= sel. This keeps the grant fixed until accept, as Avalon requires stable commands.
- On s_readdatavalid:
  - The FIFO head is popped and mi_readdatavalid is asserted for i = head, in the same cycle.
  - If the FIFO is empty, no master sees readdatavalid and rdv_err <= 1 (sticky until reset).
- Simultaneous push and pop: count unchanged, and a FIFO at MAX_PEND stays full. Pointers wrap modulo MAX_PEND.
- Writes never enter the FIFO and are never blocked by a full FIFO.
- Reset mid-operation: all state clears asynchronously. The SDRAM controller shares reset_n, so no stale read data is expected afterwards.

## Timing
- Command path is combinational: a master's command reaches s_* in the same cycle, with 0 added latency.
- Read data path is combinational: s_readdatavalid → mi_readdatavalid in the same cycle.
- Back-to-back accepts are allowed every cycle. Contending masters alternate per accepted command, so neither is granted more than one command in a row while the other is requesting.
- After a full FIFO pops, the next read can be accepted in that same cycle.
- Read responses return in issue order, so the tag sequence exactly matches controller return order.

## Test plan
- **Reset:** reset_n = 0 with random inputs. Require s_read = s_write = 0, both waitrequests = 1, pending_count = 0, rdv_err = 0.
- **Contention:** m0 and m1 both issue continuous reads (m0 addr 0x100, m1 addr 0x200), with s_waitrequest = 0 and the slave returning data after 3 cycles. Require:
  - s_address alternates 0x100, 0x200, 0x100, …, starting with m0.
  - Each master receives exactly its own readdatavalid pulses, in order.
- **Stall hold:** m1 write (addr 0x40, data 0xDEADBEEF) with s_waitrequest = 1 for 4 cycles while m0 raises a read. Require:
  - s_* hold m1's write for all 5 cycles.
  - m0 is granted on the cycle after m1's accept.
- **FIFO full:** slave accepts 8 m0 reads with no readdatavalid. Require:
  - 9th read stalls with pending_count = 8 and s_read = 0.
  - An m1 write in that period still passes through.
  - One readdatavalid pulse releases the 9th read in the same cycle.
- **Simultaneous push/pop:** at pending_count = 3, an accepted read coincides with readdatavalid. Require count stays 3 and the tag order is preserved.
- **Spurious data:** s_readdatavalid = 1 with an empty FIFO. Require no mi_readdatavalid, and rdv_err = 1 held until reset_n = 0.
